posit_to_fixed_stream: RTL

POSIT_TO_FIXED_STREAM -- requirements
Module: posit_to_fixed_stream

---
 rtl/posit_mac_pkg.sv | 20 ++
 rtl/posit8_unpack.sv | 39 +++
 rtl/posit_to_fixed_stream.sv | 105 ++++++++++
 3 files changed

// File: rtl/posit_mac_pkg.sv
// Shared posit8 (es=0) constants and the decoded-field record used across the
// posit MAC datapath.
package posit_mac_pkg;

  localparam int          POSIT_W     = 8;
  localparam int          POSIT_ES    = 0;
  localparam logic [7:0]  POSIT_NAR   = 8'h80;
  localparam logic [7:0]  POSIT_ZERO  = 8'h00;
  localparam int          POSIT_MAX_K = 6;

  // frac carries the hidden 1 in bit 5, fraction bits left-aligned below it.
  typedef struct packed {
    logic              sign;
    logic signed [3:0] k;
    logic [5:0]        frac;
    logic              z;
    logic              nar;
  } posit8_fields_t;

endpackage

// File: rtl/posit8_unpack.sv
// Combinational posit8 (es=0) field decoder: sign, regime k, hidden-bit
// fraction, zero and NaR flags.
module posit8_unpack
  import posit_mac_pkg::*;
(
  input  logic [7:0]     word_i,
  output posit8_fields_t fields_o
);

  logic [6:0] body;
  logic [3:0] run;
  logic       done;
  logic [4:0] tail;

  always_comb begin
    body = word_i[7] ? (~word_i[6:0] + 7'd1) : word_i[6:0];
    run  = 4'd0;
    done = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!done) begin
        if (body[i] == body[6]) run = run + 4'd1;
        else                    done = 1'b1;
      end
    end
    // Regime plus terminator occupy run+1 bits; left-align what remains.
    tail = body[4:0] << (run - 4'd1);

    fields_o.sign = word_i[7];
    fields_o.k    = body[6] ? $signed(run - 4'd1) : $signed(4'd0 - run);
    fields_o.frac = {1'b1, tail};
    fields_o.z    = (word_i == POSIT_ZERO);
    fields_o.nar  = (word_i == POSIT_NAR);
    if (fields_o.z || fields_o.nar) begin
      fields_o.k    = 4'sd0;
      fields_o.frac = 6'd0;
    end
  end

endmodule

// File: rtl/posit_to_fixed_stream.sv
// Streaming posit8 -> signed Q8.FRAC_BITS converter, 2-stage pipeline with
// valid/ready on both sides. Define POSIT_NAR_CNT_EN to add the nar_cnt counter.
module posit_to_fixed_stream
  import posit_mac_pkg::*;
#(
  parameter  int FRAC_BITS = 8,
  localparam int OW        = 8 + FRAC_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_nar
`ifdef POSIT_NAR_CNT_EN
  ,
  output logic [7:0]    nar_cnt
`endif
);

  // Handshake: a word moves when valid & ready are both high at the rising
  // edge; valid never depends on ready, ready may depend on downstream ready.

  posit8_fields_t dec;
  posit8_fields_t s1_q, s1_d;
  logic           s1_valid_q;
  logic           s2_load, s1_load;

  logic [3:0]     sh;
  logic [17:0]    mag_full;
  logic [OW-1:0]  mag;
  logic [OW-1:0]  out_data_q, out_data_d;
  logic           out_valid_q, out_nar_q;

  posit8_unpack u_unpack (
    .word_i   (in_data),
    .fields_o (dec)
  );

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign s1_d     = dec;

  // frac is 1.f * 2^5; shifting by k+6 gives value * 2^11, then drop the
  // surplus scale. The dropped low bits are always zero for FRAC_BITS >= 6.
  always_comb begin
    sh       = $unsigned(s1_q.k) + 4'd6;
    mag_full = {12'd0, s1_q.frac} << sh;
    mag      = OW'(mag_full >> (11 - FRAC_BITS));
    if (s1_q.nar)       out_data_d = {1'b1, {(OW-1){1'b0}}};
    else if (s1_q.z)    out_data_d = '0;
    else if (s1_q.sign) out_data_d = -mag;
    else                out_data_d = mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nar_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        out_nar_q  <= s1_q.nar;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nar   = out_nar_q;

`ifdef POSIT_NAR_CNT_EN
  logic [7:0] nar_cnt_q, nar_cnt_d;

  always_comb begin
    nar_cnt_d = nar_cnt_q;
    if (out_valid_q && out_ready && out_nar_q && (nar_cnt_q != 8'hFF))
      nar_cnt_d = nar_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nar_cnt_q <= 8'd0;
    else        nar_cnt_q <= nar_cnt_d;
  end

  assign nar_cnt = nar_cnt_q;
`endif

endmodule
